// File: rtl/alu_sched.sv
// +--------------------------------------------------------------------------+
// | alu_sched : request sequencer driving a 16-bit ALU; MUL as shift-and-add  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module alu_sched (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [15:0] resp_result,
  output logic        resp_zero,
  output logic        resp_neg,
  output logic        resp_err,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [15:0] alu_result,
  input  logic        alu_zero,
  input  logic        alu_neg
);

  localparam logic [3:0] c_op_add = 4'd0;
  localparam logic [3:0] c_op_sll = 4'd4;
  localparam logic [3:0] c_op_max = 4'd5;
  localparam logic [3:0] c_op_mul = 4'b1000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_BIT  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [3:0]  r_op;
  logic [15:0] r_a;      // operand A; multiplicand during BIT
  logic [15:0] r_b;      // operand B; remaining multiplier during BIT
  logic [15:0] r_acc;
  logic        r_added;
  logic [15:0] r_resp_result;
  logic        r_resp_zero;
  logic        r_resp_neg;
  logic        r_resp_err;
  logic        w_add_step;
  logic        w_mul_last;

  assign w_add_step = r_b[0] & ~r_added;
  assign w_mul_last = ~w_add_step && (r_b[15:1] == 15'd0);

  assign req_ready   = (r_state == S_IDLE);
  assign resp_valid  = (r_state == S_DONE);
  assign resp_result = r_resp_result;
  assign resp_zero   = r_resp_zero;
  assign resp_neg    = r_resp_neg;
  assign resp_err    = r_resp_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    alu_a        = 16'd0;
    alu_b        = 16'd0;
    alu_op       = c_op_add;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          if (req_op <= c_op_max)                         w_next_state = S_EXEC;
          else if (req_op == c_op_mul && req_b != 16'd0)  w_next_state = S_BIT;
          else                                            w_next_state = S_DONE;
        end
      end
      S_EXEC: begin
        alu_a        = r_a;
        alu_b        = r_b;
        alu_op       = r_op;
        w_next_state = S_DONE;
      end
      S_BIT: begin
        if (w_add_step) begin
          alu_a  = r_acc;
          alu_b  = r_a;
          alu_op = c_op_add;
        end else begin
          alu_a  = r_a;
          alu_b  = 16'd1;
          alu_op = c_op_sll;
        end
        if (w_mul_last) w_next_state = S_DONE;
      end
      S_DONE: begin
        if (resp_ready) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op          <= 4'd0;
      r_a           <= 16'd0;
      r_b           <= 16'd0;
      r_acc         <= 16'd0;
      r_added       <= 1'b0;
      r_resp_result <= 16'd0;
      r_resp_zero   <= 1'b0;
      r_resp_neg    <= 1'b0;
      r_resp_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_op    <= req_op;
            r_a     <= req_a;
            r_b     <= req_b;
            r_acc   <= 16'd0;
            r_added <= 1'b0;
            // Requests that finish without touching the ALU load a zero result now
            if (req_op > c_op_max && (req_op != c_op_mul || req_b == 16'd0)) begin
              r_resp_result <= 16'd0;
              r_resp_zero   <= 1'b1;
              r_resp_neg    <= 1'b0;
              r_resp_err    <= (req_op != c_op_mul);
            end
          end
        end
        S_EXEC: begin
          r_resp_result <= alu_result;
          r_resp_zero   <= alu_zero;
          r_resp_neg    <= alu_neg;
          r_resp_err    <= 1'b0;
        end
        S_BIT: begin
          if (w_add_step) begin
            r_acc   <= alu_result;
            r_added <= 1'b1;
          end else begin
            r_a     <= alu_result;
            r_b     <= {1'b0, r_b[15:1]};
            r_added <= 1'b0;
            if (w_mul_last) begin
              r_resp_result <= r_acc;
              r_resp_zero   <= (r_acc == 16'd0);
              r_resp_neg    <= r_acc[15];
              r_resp_err    <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_sched.sv
// +--------------------------------------------------------------------------+
// | tb_alu_sched : directed self-checking bench for alu_sched                 |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_alu_sched;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_result;
  logic        resp_zero;
  logic        resp_neg;
  logic        resp_err;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [3:0]  alu_op;
  logic [15:0] alu_result;
  logic        alu_zero;
  logic        alu_neg;

  int checks;
  int failures;
  logic [3:0]  op_trace [0:63];
  logic [15:0] a_trace  [0:63];
  logic [15:0] b_trace  [0:63];

  alu_sched dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
    .resp_zero(resp_zero), .resp_neg(resp_neg), .resp_err(resp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_neg(alu_neg)
  );

  // Reference model of the external combinational ALU
  always_comb begin
    case (alu_op)
      4'd0:    alu_result = alu_a + alu_b;
      4'd1:    alu_result = alu_a - alu_b;
      4'd2:    alu_result = alu_a & alu_b;
      4'd3:    alu_result = alu_a | alu_b;
      4'd4:    alu_result = alu_a << alu_b[3:0];
      4'd5:    alu_result = alu_b;
      default: alu_result = 16'd0;
    endcase
    alu_zero = (alu_result == 16'd0);
    alu_neg  = alu_result[15];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request, then wait until resp_valid; lat = cycle index, -1 on timeout
  task automatic run_req(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         output int lat);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      op_trace[k] = alu_op; a_trace[k] = alu_a; b_trace[k] = alu_b;
      if (resp_valid) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic take_resp();
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_result !== 16'd0 ||
        resp_zero !== 1'b0 || resp_neg !== 1'b0 || resp_err !== 1'b0) begin
      $display("FAIL reset_outputs: rdy=%b vld=%b res=%h z=%b n=%b e=%b expected 1 0 0000 0 0 0",
               req_ready, resp_valid, resp_result, resp_zero, resp_neg, resp_err);
      failures++;
    end
    checks++;
    if (alu_a !== 16'd0 || alu_b !== 16'd0 || alu_op !== 4'd0) begin
      $display("FAIL reset_alu_idle: a=%h b=%h op=%0d expected 0 0 0", alu_a, alu_b, alu_op);
      failures++;
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add();
    int lat;
    run_req(4'd0, 16'h1234, 16'h0F0F, lat);
    checks++;
    if (lat !== 2) begin
      $display("FAIL add_latency: got %0d expected 2", lat); failures++;
    end
    checks++;
    if (resp_result !== 16'h2143 || resp_zero !== 1'b0 || resp_neg !== 1'b0 || resp_err !== 1'b0) begin
      $display("FAIL add_result: res=%h z=%b n=%b e=%b expected 2143 0 0 0",
               resp_result, resp_zero, resp_neg, resp_err);
      failures++;
    end
    checks++;
    if (a_trace[1] !== 16'h1234 || b_trace[1] !== 16'h0F0F || op_trace[1] !== 4'd0 ||
        a_trace[2] !== 16'h0000 || b_trace[2] !== 16'h0000) begin
      $display("FAIL add_alu_drive: c1 a=%h b=%h op=%0d c2 a=%h b=%h expected 1234 0f0f 0 / 0 0",
               a_trace[1], b_trace[1], op_trace[1], a_trace[2], b_trace[2]);
      failures++;
    end
    checks++;
    if (req_ready !== 1'b0) begin
      $display("FAIL add_ready_in_done: got %b expected 0", req_ready); failures++;
    end
    take_resp();
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      $display("FAIL add_handoff: vld=%b rdy=%b expected 0 1", resp_valid, req_ready); failures++;
    end
  endtask

  task automatic test_sub_lui();
    int lat;
    run_req(4'd1, 16'd5, 16'd5, lat);
    checks++;
    if (lat !== 2 || resp_result !== 16'h0000 || resp_zero !== 1'b1 || resp_neg !== 1'b0) begin
      $display("FAIL sub_zero: lat=%0d res=%h z=%b n=%b expected 2 0000 1 0",
               lat, resp_result, resp_zero, resp_neg);
      failures++;
    end
    take_resp();
    run_req(4'd1, 16'd0, 16'd1, lat);
    checks++;
    if (lat !== 2 || resp_result !== 16'hFFFF || resp_zero !== 1'b0 || resp_neg !== 1'b1) begin
      $display("FAIL sub_neg: lat=%0d res=%h z=%b n=%b expected 2 ffff 0 1",
               lat, resp_result, resp_zero, resp_neg);
      failures++;
    end
    take_resp();
    run_req(4'd5, 16'h5A5A, 16'hAB00, lat);
    checks++;
    if (lat !== 2 || resp_result !== 16'hAB00 || resp_neg !== 1'b1) begin
      $display("FAIL lui: lat=%0d res=%h n=%b expected 2 ab00 1", lat, resp_result, resp_neg);
      failures++;
    end
    take_resp();
  endtask

  task automatic test_mul();
    int lat;
    run_req(4'b1000, 16'd3, 16'd5, lat);
    checks++;
    if (lat !== 6 || resp_result !== 16'd15 || resp_zero !== 1'b0 || resp_err !== 1'b0) begin
      $display("FAIL mul_3x5: lat=%0d res=%h z=%b e=%b expected 6 000f 0 0",
               lat, resp_result, resp_zero, resp_err);
      failures++;
    end
    checks++;
    if (op_trace[1] !== 4'd0 || op_trace[2] !== 4'd4 || op_trace[3] !== 4'd4 ||
        op_trace[4] !== 4'd0 || op_trace[5] !== 4'd4) begin
      $display("FAIL mul_3x5_ops: got %0d %0d %0d %0d %0d expected 0 4 4 0 4",
               op_trace[1], op_trace[2], op_trace[3], op_trace[4], op_trace[5]);
      failures++;
    end
    checks++;
    if (b_trace[1] !== 16'd3 || b_trace[2] !== 16'd1 || a_trace[3] !== 16'd6 ||
        a_trace[4] !== 16'd3 || b_trace[4] !== 16'd12 || a_trace[5] !== 16'd12) begin
      $display("FAIL mul_3x5_operands: b1=%h b2=%h a3=%h a4=%h b4=%h a5=%h expected 3 1 6 3 c c",
               b_trace[1], b_trace[2], a_trace[3], a_trace[4], b_trace[4], a_trace[5]);
      failures++;
    end
    take_resp();
    run_req(4'b1000, 16'h0100, 16'h0100, lat);
    checks++;
    if (lat !== 11 || resp_result !== 16'h0000 || resp_zero !== 1'b1) begin
      $display("FAIL mul_wrap: lat=%0d res=%h z=%b expected 11 0000 1", lat, resp_result, resp_zero);
      failures++;
    end
    take_resp();
    run_req(4'b1000, 16'hFFFF, 16'hFFFF, lat);
    checks++;
    if (lat !== 33 || resp_result !== 16'h0001 || resp_neg !== 1'b0) begin
      $display("FAIL mul_max: lat=%0d res=%h n=%b expected 33 0001 0", lat, resp_result, resp_neg);
      failures++;
    end
    take_resp();
    run_req(4'b1000, 16'h1234, 16'h0000, lat);
    checks++;
    if (lat !== 1 || resp_result !== 16'h0000 || resp_zero !== 1'b1 || resp_err !== 1'b0) begin
      $display("FAIL mul_by_zero: lat=%0d res=%h z=%b e=%b expected 1 0000 1 0",
               lat, resp_result, resp_zero, resp_err);
      failures++;
    end
    take_resp();
  endtask

  task automatic test_illegal();
    int lat;
    run_req(4'b0110, 16'h1111, 16'h2222, lat);
    checks++;
    if (lat !== 1 || resp_result !== 16'h0000 || resp_err !== 1'b1) begin
      $display("FAIL illegal_op: lat=%0d res=%h e=%b expected 1 0000 1", lat, resp_result, resp_err);
      failures++;
    end
    take_resp();
    run_req(4'd0, 16'd1, 16'd1, lat);
    checks++;
    if (lat !== 2 || resp_result !== 16'd2 || resp_err !== 1'b0) begin
      $display("FAIL after_illegal_add: lat=%0d res=%h e=%b expected 2 0002 0", lat, resp_result, resp_err);
      failures++;
    end
    take_resp();
  endtask

  task automatic test_backpressure();
    int lat;
    int bad;
    run_req(4'b1000, 16'd7, 16'd9, lat);
    checks++;
    if (lat !== 7 || resp_result !== 16'd63) begin
      $display("FAIL bp_mul_7x9: lat=%0d res=%h expected 7 003f", lat, resp_result);
      failures++;
    end
    bad = 0;
    req_valid = 1'b1; req_op = 4'd1; req_a = 16'hAAAA; req_b = 16'h0001;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_result !== 16'd63) bad++;
    end
    req_valid = 1'b0;
    checks++;
    if (bad != 0) begin
      $display("FAIL bp_hold: %0d unstable cycles, expected 0", bad); failures++;
    end
    take_resp();
    checks++;
    if (resp_valid !== 1'b0 || resp_result !== 16'd63) begin
      $display("FAIL bp_after_take: vld=%b res=%h expected 0 003f", resp_valid, resp_result);
      failures++;
    end
  endtask

  task automatic test_reset_mid_bit();
    int lat;
    int seen;
    @(negedge clk);
    req_valid = 1'b1; req_op = 4'b1000; req_a = 16'hFFFF; req_b = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_result !== 16'd0 ||
        resp_zero !== 1'b0 || resp_err !== 1'b0 || alu_a !== 16'd0 || alu_op !== 4'd0) begin
      $display("FAIL reset_mid_bit: rdy=%b vld=%b res=%h z=%b e=%b alu_a=%h op=%0d expected 1 0 0 0 0 0 0",
               req_ready, resp_valid, resp_result, resp_zero, resp_err, alu_a, alu_op);
      failures++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      $display("FAIL reset_drops_resp: resp_valid seen %0d cycles expected 0", seen); failures++;
    end
    run_req(4'd0, 16'd2, 16'd3, lat);
    checks++;
    if (lat !== 2 || resp_result !== 16'd5) begin
      $display("FAIL after_reset_add: lat=%0d res=%h expected 2 0005", lat, resp_result);
      failures++;
    end
    take_resp();
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; req_valid = 1'b0; req_op = 4'd0; req_a = 16'd0; req_b = 16'd0;
    resp_ready = 1'b0;
    test_reset();
    test_add();
    test_sub_lui();
    test_mul();
    test_illegal();
    test_backpressure();
    test_reset_mid_bit();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
